smvm_stream_tx: RTL and testbench

SMVM_STREAM_TX -- requirements
Module: smvm_stream_tx

---
 rtl/smvm_stream_tx_if.sv | 34 +++
 rtl/smvm_stream_tx.sv | 174 +++++++++++++++++
 tb/tb_smvm_stream_tx.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/smvm_stream_tx_if.sv
// Bus bundle for smvm_stream_tx: job control, memory read ports,
// accelerator stream and result counter.
interface smvm_stream_tx_if;
    logic        start;
    logic [8:0]  rows;
    logic [8:0]  cols;
    logic [10:0] nnz;
    logic        busy;
    logic        err;
    logic        done;
    logic [8:0]  vec_raddr;
    logic [7:0]  vec_rdata;
    logic [10:0] nz_raddr;
    logic [17:0] nz_rdata;
    logic        in_valid;
    logic [7:0]  val_in;
    logic        ipv_in;
    logic        res_valid;
    logic [9:0]  res_count;

    // Transmitter side
    modport master (
        input  start, rows, cols, nnz, vec_rdata, nz_rdata, res_valid,
        output busy, err, done, vec_raddr, nz_raddr, in_valid, val_in,
               ipv_in, res_count
    );

    // Job issuer / memories / accelerator side
    modport slave (
        output start, rows, cols, nnz, vec_rdata, nz_rdata, res_valid,
        input  busy, err, done, vec_raddr, nz_raddr, in_valid, val_in,
               ipv_in, res_count
    );
endinterface

// File: rtl/smvm_stream_tx.sv
// smvm_stream_tx: serialises one sparse matrix-vector job (header, dense
// vector, VAL/IDX nonzero pairs, terminator, idle gap) into the
// accelerator input stream and counts returned results.
// Optional macro SMVM_TX_PAD_EN: pad the pair count up to a multiple of K
// with all-zero pairs that do not touch nonzero memory.
module smvm_stream_tx #(
    parameter int unsigned K          = 4,
    parameter int unsigned GAP_CYCLES = 6
) (
    input logic               clk,
    input logic               rst,
    smvm_stream_tx_if.master  bus
);
    localparam int unsigned PW = 12;
    localparam int unsigned GW = 16;
`ifdef SMVM_TX_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, HDR_ROW, HDR_COL, VEC, NZ_VAL, NZ_IDX, TERM, GAP
    } state_t;

    state_t          state;
    logic [8:0]      rows_q;
    logic [8:0]      cols_q;
    logic [10:0]     nnz_q;
    logic [PW-1:0]   npairs_q;
    logic [PW-1:0]   pair_idx;
    logic [8:0]      vec_idx;
    logic [GW-1:0]   gap_cnt;
    logic            busy_q;
    logic            err_q;
    logic            done_q;
    logic            in_valid_q;
    logic [8:0]      vec_raddr_q;
    logic [10:0]     nz_raddr_q;
    logic [9:0]      res_count_q;
    logic [PW-1:0]   npairs_c;
    logic            pad_c;
    logic [8:0]      word_c;

    // Pair count for a new job, optionally rounded up to a whole ALU group
    assign npairs_c = PAD_EN ? PW'(((32'(bus.nnz) + K - 1) / K) * K)
                             : PW'(bus.nnz);

    // Pairs beyond the real nonzero count are padding
    assign pad_c = (pair_idx >= PW'(nnz_q));

    // Stream word {val_in, ipv_in}; memory data is forwarded directly since
    // the read address is issued one cycle ahead of the element
    always_comb begin
        word_c = '0;
        case (state)
            HDR_ROW: word_c = rows_q;
            HDR_COL: word_c = cols_q;
            VEC:     word_c = {bus.vec_rdata, 1'b0};
            NZ_VAL:  if (!pad_c) word_c = {bus.nz_rdata[17:10], bus.nz_rdata[0]};
            NZ_IDX:  if (!pad_c) word_c = bus.nz_rdata[9:1];
            default: word_c = '0;
        endcase
    end

    assign bus.val_in    = word_c[8:1];
    assign bus.ipv_in    = word_c[0];
    assign bus.in_valid  = in_valid_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
    assign bus.done      = done_q;
    assign bus.vec_raddr = vec_raddr_q;
    assign bus.nz_raddr  = nz_raddr_q;
    assign bus.res_count = res_count_q;

    // Job sequencer with registered control outputs and result counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rows_q      <= '0;
            cols_q      <= '0;
            nnz_q       <= '0;
            npairs_q    <= '0;
            pair_idx    <= '0;
            vec_idx     <= '0;
            gap_cnt     <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            in_valid_q  <= 1'b0;
            vec_raddr_q <= '0;
            nz_raddr_q  <= '0;
            res_count_q <= '0;
        end else begin
            err_q  <= 1'b0;
            done_q <= 1'b0;
            if (bus.res_valid && (res_count_q != 10'h3FF)) begin
                res_count_q <= res_count_q + 10'd1;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if ((bus.rows != 9'd0) && (bus.cols != 9'd0)) begin
                            rows_q      <= bus.rows;
                            cols_q      <= bus.cols;
                            nnz_q       <= bus.nnz;
                            npairs_q    <= npairs_c;
                            res_count_q <= '0;
                            vec_raddr_q <= '0;
                            nz_raddr_q  <= '0;
                            busy_q      <= 1'b1;
                            in_valid_q  <= 1'b1;
                            state       <= HDR_ROW;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                HDR_ROW: state <= HDR_COL;
                HDR_COL: begin
                    vec_idx     <= '0;
                    vec_raddr_q <= (cols_q > 9'd1) ? 9'd1 : 9'd0;
                    state       <= VEC;
                end
                VEC: begin
                    if (vec_raddr_q < (cols_q - 9'd1)) begin
                        vec_raddr_q <= vec_raddr_q + 9'd1;
                    end
                    if (vec_idx == (cols_q - 9'd1)) begin
                        pair_idx <= '0;
                        if (npairs_q == '0) begin
                            in_valid_q <= 1'b0;
                            state      <= TERM;
                        end else begin
                            state <= NZ_VAL;
                        end
                    end else begin
                        vec_idx <= vec_idx + 9'd1;
                    end
                end
                NZ_VAL: begin
                    // Prefetch the next real entry; padding never reads memory
                    if ((pair_idx + PW'(1)) < PW'(nnz_q)) begin
                        nz_raddr_q <= 11'(pair_idx + PW'(1));
                    end
                    state <= NZ_IDX;
                end
                NZ_IDX: begin
                    if (pair_idx == (npairs_q - PW'(1))) begin
                        in_valid_q <= 1'b0;
                        state      <= TERM;
                    end else begin
                        pair_idx <= pair_idx + PW'(1);
                        state    <= NZ_VAL;
                    end
                end
                TERM: begin
                    gap_cnt <= '0;
                    state   <= GAP;
                end
                GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_smvm_stream_tx.sv
// Testbench for smvm_stream_tx: a job-level model expands each accepted
// start into the expected per-cycle stream; a compare process checks every
// cycle, and directed checks pin key timings to literal values.
module tb_smvm_stream_tx;
    localparam int GAP = 6;
`ifdef SMVM_TX_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    typedef struct {
        int       cyc;
        bit       busy;
        bit       iv;
        bit [8:0] word;
        bit       done;
        bit       err;
    } exp_t;

    logic clk;
    logic rst;
    smvm_stream_tx_if bus ();

    smvm_stream_tx #(.K(4), .GAP_CYCLES(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0]  vec_mem [512];
    logic [17:0] nz_mem  [2048];
    exp_t        q [$];
    int          cyc;
    int          pt;
    int          rc;
    bit          busy_now;
    int          nzmax;
    bit          rv_mode;
    int          checks;
    int          errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory models
    always @(posedge clk) begin
        bus.vec_rdata <= vec_mem[bus.vec_raddr];
        bus.nz_rdata  <= nz_mem[bus.nz_raddr];
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, exp);
        end
    endtask

    function automatic void push_e(input bit b, input bit iv, input bit [8:0] w,
                                   input bit d, input bit e);
        exp_t x;
        x.cyc = pt; x.busy = b; x.iv = iv; x.word = w; x.done = d; x.err = e;
        q.push_back(x);
        pt++;
    endfunction

    // Expected stream for a job whose start was sampled at the end of cycle c
    function automatic void build_job(input int c, input int r, input int co, input int n);
        int np;
        logic [17:0] ent;
        np = PAD ? ((n + 3) / 4) * 4 : n;
        pt = c + 1;
        push_e(1, 1, 9'(r), 0, 0);
        push_e(1, 1, 9'(co), 0, 0);
        for (int i = 0; i < co; i++) push_e(1, 1, {vec_mem[i], 1'b0}, 0, 0);
        for (int j = 0; j < np; j++) begin
            if (j < n) begin
                ent = nz_mem[j];
                push_e(1, 1, {ent[17:10], ent[0]}, 0, 0);
                push_e(1, 1, ent[9:1], 0, 0);
            end else begin
                push_e(1, 1, 9'd0, 0, 0);
                push_e(1, 1, 9'd0, 0, 0);
            end
        end
        push_e(1, 0, 9'd0, 0, 0);
        for (int g = 0; g < GAP; g++) push_e(1, 0, 9'd0, 0, 0);
        push_e(0, 0, 9'd0, 1, 0);
    endfunction

    // Per-cycle compare (negedge) and job-level model update (posedge)
    initial begin
        exp_t e;
        cyc = 0; rc = 0; busy_now = 0; nzmax = 0;
        forever begin
            @(negedge clk);
            e.cyc = cyc; e.busy = 0; e.iv = 0; e.word = 0; e.done = 0; e.err = 0;
            if (rst) begin
                q.delete();
                rc = 0;
            end else if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
            end
            busy_now = e.busy;
            chk("busy", int'(bus.busy), int'(e.busy));
            chk("in_valid", int'(bus.in_valid), int'(e.iv));
            chk("word", int'({bus.val_in, bus.ipv_in}), int'(e.word));
            chk("done", int'(bus.done), int'(e.done));
            chk("err", int'(bus.err), int'(e.err));
            chk("res_count", int'(bus.res_count), rc);
            if (bus.busy && int'(bus.nz_raddr) > nzmax) nzmax = int'(bus.nz_raddr);
            @(posedge clk);
            if (rst) begin
                q.delete();
                rc = 0;
            end else begin
                if (bus.start && !busy_now) begin
                    if (bus.rows != 0 && bus.cols != 0) begin
                        build_job(cyc, int'(bus.rows), int'(bus.cols), int'(bus.nnz));
                        rc = 0;
                    end else begin
                        pt = cyc + 1;
                        push_e(0, 0, 9'd0, 0, 1);
                    end
                end
                if (!(bus.start && !busy_now && bus.rows != 0 && bus.cols != 0)
                    && bus.res_valid && rc < 1023) rc++;
            end
            cyc++;
        end
    end

    // Accelerator result strobes
    initial begin
        bus.res_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.res_valid = rv_mode ? 1'b1 : ((cyc % 5) == 1 || (cyc % 5) == 2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int r, input int co, input int n);
        bus.start = 1'b1;
        bus.rows  = 9'(r);
        bus.cols  = 9'(co);
        bus.nnz   = 11'(n);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        while ((q.size() != 0 || bus.busy) && n < 300) begin
            tick();
            n++;
        end
        chk("quiet_timeout", int'(n < 300), 1);
        tick();
    endtask

    task automatic wait_fall(output int t);
        int n;
        n = 0;
        while (bus.in_valid && n < 100) begin
            tick();
            n++;
        end
        chk("fall_timeout", int'(n < 100), 1);
        t = cyc;
    endtask

    task automatic wait_done(output int t);
        int n;
        n = 0;
        while (!bus.done && n < 100) begin
            tick();
            n++;
        end
        chk("done_timeout", int'(n < 100), 1);
        t = cyc;
    endtask

    // Reference job (3x4, 4 nonzeros): TERM 14 and done 21 cycles after HDR_ROW
    task automatic ref_job();
        int t0, tt, td;
        t0 = cyc;
        chk("hdr_valid", int'(bus.in_valid), 1);
        chk("hdr_rows", int'({bus.val_in, bus.ipv_in}), 3);
        wait_fall(tt);
        chk("term_cycle", tt - t0, 14);
        wait_done(td);
        chk("done_cycle", td - t0, 21);
    endtask

    initial begin
        int t0, tt, td;
        for (int i = 0; i < 512; i++) vec_mem[i] = 8'(i + 1);
        for (int j = 0; j < 2048; j++)
            nz_mem[j] = {8'(16 * j + 5), 9'((3 * j + 1) % 511), 1'(j % 2)};
        checks = 0; errors = 0; rv_mode = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.rows = '0; bus.cols = '0; bus.nnz = '0;
        repeat (3) tick();
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_in_valid", int'(bus.in_valid), 0);
        chk("reset_res_count", int'(bus.res_count), 0);
        rst = 1'b0;

        // Reference job
        do_start(3, 4, 4);
        ref_job();
        wait_quiet();

        // Rejected start: zero columns
        do_start(2, 0, 3);
        chk("err_pulse", int'(bus.err), 1);
        chk("err_busy", int'(bus.busy), 0);
        tick();
        chk("err_clear", int'(bus.err), 0);
        chk("err_no_stream", int'(bus.in_valid), 0);
        wait_quiet();

        // No nonzeros: TERM right after the vector
        do_start(5, 2, 0);
        t0 = cyc;
        wait_fall(tt);
        chk("nnz0_term", tt - t0, 4);
        wait_done(td);
        chk("nnz0_done", td - tt, 7);
        wait_quiet();

        // Five nonzeros: padded to 8 pairs or sent as 5
        nzmax = 0;
        do_start(1, 2, 5);
        t0 = cyc;
        wait_fall(tt);
        chk("pairs_len", tt - t0, PAD ? 20 : 14);
        wait_quiet();
        chk("nz_raddr_max", nzmax, 4);

        // Start during VEC is ignored; next start right after done
        do_start(3, 4, 4);
        tick();
        tick();
        bus.start = 1'b1; bus.rows = 9'd7; bus.cols = 9'd1; bus.nnz = 11'd0;
        tick();
        bus.start = 1'b0;
        wait_done(td);
        tick();
        do_start(2, 3, 2);
        chk("second_hdr", int'({bus.val_in, bus.ipv_in}), 2);
        wait_quiet();

        // Reset during NZ_IDX aborts; fresh job on the release edge
        do_start(3, 4, 4);
        repeat (7) tick();
        chk("pre_rst_iv", int'(bus.in_valid), 1);
        rst = 1'b1;
        #1;
        chk("rst_iv", int'(bus.in_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        tick();
        tick();
        rst = 1'b0;
        do_start(3, 4, 4);
        ref_job();
        wait_quiet();

        // Result counter saturation
        rv_mode = 1'b1;
        repeat (1100) tick();
        chk("rc_sat", int'(bus.res_count), 1023);
        rv_mode = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
